// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the radix-2^K sequential multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit widths the partial-product unit supports.
    function automatic bit k_is_legal(input int k);
        return (k == 1) || (k == 2) || (k == 4);
    endfunction

endpackage

// File: rtl/seq_mult_digit_pp.sv
// Partial product of the shifted multiplicand and one K-bit multiplier digit.
module seq_mult_digit_pp
    import seq_mult_pkg::*;
#(
    parameter int Z_W = 32,
    parameter int K   = 2
) (
    input  logic [Z_W-1:0] mcand,
    input  logic [K-1:0]   digit,
    output logic [Z_W-1:0] pp
);

    generate
        if (!k_is_legal(K)) begin : g_bad_k
            $error("seq_mult_digit_pp: digit width K must be 1, 2 or 4");
        end
    endgenerate

    // Shift-add of the multiplicand for every set bit of the digit.
    always_comb begin
        pp = '0;
        for (int i = 0; i < K; i++) begin
            if (digit[i]) begin
                pp = pp + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/seq_mult_radix.sv
// Sequential multiplier retiring BITS_PER_CYCLE multiplier bits per cycle on
// operand magnitudes, with sign fix-up at the end and early exit once the
// remaining multiplier bits are zero. Valid/ready on both sides.
module seq_mult_radix
    import seq_mult_pkg::*;
#(
    parameter int A_W            = 16,
    parameter int B_W            = 16,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               is_signed,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [A_W+B_W-1:0] z,
    output logic               z_valid,
    input  logic               z_ready,
    output logic               busy
);

    localparam int Z_W = A_W + B_W;
    localparam int K   = BITS_PER_CYCLE;

    state_t         state, state_nxt;
    logic [Z_W-1:0] mcand, mcand_nxt;
    logic [Z_W-1:0] acc, acc_nxt;
    logic [Z_W-1:0] z_reg, z_nxt;
    logic [B_W-1:0] mplier, mplier_nxt;
    logic           neg, neg_nxt;
    logic           z_valid_reg, z_valid_nxt;

    logic [A_W-1:0] a_mag;
    logic [B_W-1:0] b_mag;
    logic [Z_W-1:0] pp;
    logic [Z_W-1:0] acc_sum;
    logic [B_W-1:0] mplier_sh;

    seq_mult_digit_pp #(
        .Z_W (Z_W),
        .K   (K)
    ) u_digit_pp (
        .mcand (mcand),
        .digit (mplier[K-1:0]),
        .pp    (pp)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            neg         <= 1'b0;
            z_reg       <= '0;
            z_valid_reg <= 1'b0;
        end else begin
            state       <= state_nxt;
            mcand       <= mcand_nxt;
            mplier      <= mplier_nxt;
            acc         <= acc_nxt;
            neg         <= neg_nxt;
            z_reg       <= z_nxt;
            z_valid_reg <= z_valid_nxt;
        end
    end

    // Next state and datapath: load magnitudes, accumulate one digit per cycle,
    // apply the sign when the remaining multiplier bits run out.
    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        acc_nxt     = acc;
        neg_nxt     = neg;
        z_nxt       = z_reg;
        z_valid_nxt = z_valid_reg;

        a_mag     = (is_signed && a[A_W-1]) ? -a : a;
        b_mag     = (is_signed && b[B_W-1]) ? -b : b;
        acc_sum   = acc + pp;
        mplier_sh = mplier >> K;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_nxt  = {{B_W{1'b0}}, a_mag};
                    mplier_nxt = b_mag;
                    acc_nxt    = '0;
                    neg_nxt    = is_signed & (a[A_W-1] ^ b[B_W-1]);
                    state_nxt  = CALC;
                end
            end
            CALC: begin
                acc_nxt    = acc_sum;
                mcand_nxt  = mcand << K;
                mplier_nxt = mplier_sh;
                if (mplier_sh == '0) begin
                    z_nxt       = neg ? -acc_sum : acc_sum;
                    z_valid_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                if (z_ready) begin
                    z_valid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state and result registers only.
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        z        = z_reg;
        z_valid  = z_valid_reg;
    end

endmodule
